// File: rtl/card_pkg.sv
// Shared types and constants for the card corner scanner.
package card_pkg;

    localparam int ADDR_W     = 17;
    localparam int DEF_WIDTH  = 240;
    localparam int DEF_HEIGHT = 320;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } scan_state_t;

    // True when the edge set cannot describe a legal card inside the image.
    // The width/height terms are only meaningful once the ordering checks pass,
    // which the OR chain guarantees.
    function automatic logic edges_rejected(
        input logic [7:0] left_v,
        input logic [7:0] right_v,
        input logic [8:0] top_v,
        input logic [8:0] bot_v,
        input int         width_v,
        input int         height_v,
        input int         min_dim_v
    );
        logic [9:0] card_w_v;
        logic [9:0] card_h_v;
        card_w_v = {2'b00, right_v} - {2'b00, left_v} + 10'd1;
        card_h_v = {1'b0, bot_v} - {1'b0, top_v} + 10'd1;
        return (left_v > right_v) ||
               (top_v > bot_v) ||
               (int'(right_v) >= width_v) ||
               (int'(bot_v) >= height_v) ||
               (int'(card_w_v) < min_dim_v) ||
               (int'(card_h_v) < min_dim_v);
    endfunction

endpackage

// File: rtl/latency_pipe.sv
// Fixed-depth register delay line used to align issue flags with BRAM read data.
module latency_pipe #(
    parameter int DEPTH = 2,
    parameter int W     = 2
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] q_out
);

    logic [W-1:0] stage_r [DEPTH];

    // Shift the flags one stage per cycle; reset flushes everything in flight.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= d_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q_out = stage_r[DEPTH-1];

endmodule

// File: rtl/corner_scanner.sv
// Reads the top-left corner region of a detected card out of the thresholded
// image BRAM and streams it in raster order.
module corner_scanner
    import card_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HEIGHT   = DEF_HEIGHT,
    parameter int CW_SHIFT = 2,
    parameter int CH_SHIFT = 2,
    parameter int MIN_DIM  = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic [7:0]        left_edge,
    input  logic [7:0]        right_edge,
    input  logic [8:0]        top_edge,
    input  logic [8:0]        bot_edge,
    output logic [ADDR_W-1:0] addr_out,
    input  logic [15:0]       pixel_in,
    output logic [15:0]       pixel_out,
    output logic              pixel_valid_out,
    output logic              pixel_last_out,
    output logic [7:0]        corner_width,
    output logic [8:0]        corner_height,
    output logic              busy_out,
    output logic              done_out,
    output logic              error_out
);

    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(WIDTH);

    scan_state_t       state_r;
    scan_state_t       state_next_s;

    logic [7:0]        left_r;
    logic [7:0]        right_r;
    logic [8:0]        top_r;
    logic [8:0]        bot_r;
    logic              edges_ok_r;

    logic [7:0]        corner_width_r;
    logic [8:0]        corner_height_r;
    logic [ADDR_W-1:0] row_base_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        x_r;
    logic [8:0]        y_r;
    logic              issue_valid_r;
    logic              issue_last_r;
    logic              busy_r;
    logic              done_r;
    logic              error_r;

    logic              bad_s;
    logic [8:0]        card_w_s;
    logic [9:0]        card_h_s;
    logic [7:0]        cw_s;
    logic [8:0]        ch_s;
    logic [ADDR_W-1:0] base_s;
    logic [7:0]        cw_m1_s;
    logic [8:0]        ch_m1_s;
    logic [7:0]        x_next_s;
    logic [8:0]        y_next_s;
    logic              last_col_s;
    logic              last_row_s;
    logic [1:0]        pipe_q_s;
    logic              pipe_valid_s;
    logic              pipe_last_s;

    // Edge validity is judged on the raw inputs so busy_out can stay low for rejected edges.
    assign bad_s = edges_rejected(left_edge, right_edge, top_edge, bot_edge,
                                  WIDTH, HEIGHT, MIN_DIM);

    // Card and corner geometry from the latched edges; the multiply is only used once per scan.
    assign card_w_s = {1'b0, right_r} - {1'b0, left_r} + 9'd1;
    assign card_h_s = {1'b0, bot_r} - {1'b0, top_r} + 10'd1;
    assign cw_s     = 8'(card_w_s >> CW_SHIFT);
    assign ch_s     = 9'(card_h_s >> CH_SHIFT);
    assign base_s   = ADDR_W'(top_r) * ROW_STRIDE + ADDR_W'(left_r);

    // Scan position bookkeeping.
    assign cw_m1_s    = corner_width_r - 8'd1;
    assign ch_m1_s    = corner_height_r - 9'd1;
    assign x_next_s   = x_r + 8'd1;
    assign y_next_s   = y_r + 9'd1;
    assign last_col_s = (x_r == cw_m1_s);
    assign last_row_s = (y_r == ch_m1_s);

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_in) begin
                    state_next_s = ST_SETUP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (edges_ok_r) begin
                    state_next_s = ST_SCAN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (issue_last_r) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_SCAN;
                end
            end
            ST_DRAIN: begin
                if (pipe_last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: edge latch, geometry, address walk and registered status flags.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            left_r          <= 8'd0;
            right_r         <= 8'd0;
            top_r           <= 9'd0;
            bot_r           <= 9'd0;
            edges_ok_r      <= 1'b0;
            corner_width_r  <= 8'd0;
            corner_height_r <= 9'd0;
            row_base_r      <= '0;
            addr_r          <= '0;
            x_r             <= 8'd0;
            y_r             <= 9'd0;
            issue_valid_r   <= 1'b0;
            issue_last_r    <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            error_r         <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    issue_valid_r <= 1'b0;
                    issue_last_r  <= 1'b0;
                    if (start_in) begin
                        left_r     <= left_edge;
                        right_r    <= right_edge;
                        top_r      <= top_edge;
                        bot_r      <= bot_edge;
                        edges_ok_r <= ~bad_s;
                        busy_r     <= ~bad_s;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (edges_ok_r) begin
                        corner_width_r  <= cw_s;
                        corner_height_r <= ch_s;
                        row_base_r      <= base_s;
                        addr_r          <= base_s;
                        x_r             <= 8'd0;
                        y_r             <= 9'd0;
                        issue_valid_r   <= 1'b1;
                        issue_last_r    <= (cw_s == 8'd1) && (ch_s == 9'd1);
                        busy_r          <= 1'b1;
                    end else begin
                        error_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    busy_r <= 1'b1;
                    if (issue_last_r) begin
                        issue_valid_r <= 1'b0;
                        issue_last_r  <= 1'b0;
                    end else if (last_col_s) begin
                        x_r          <= 8'd0;
                        y_r          <= y_next_s;
                        row_base_r   <= row_base_r + ROW_STRIDE;
                        addr_r       <= row_base_r + ROW_STRIDE;
                        issue_last_r <= (cw_m1_s == 8'd0) && (y_next_s == ch_m1_s);
                    end else begin
                        x_r          <= x_next_s;
                        addr_r       <= row_base_r + ADDR_W'(x_next_s);
                        issue_last_r <= (x_next_s == cw_m1_s) && last_row_s;
                    end
                end
                ST_DRAIN: begin
                    busy_r <= 1'b1;
                    done_r <= pipe_last_s;
                end
                ST_DONE: begin
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    latency_pipe #(
        .DEPTH (2),
        .W     (2)
    ) u_latency_pipe (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   ({issue_last_r, issue_valid_r}),
        .q_out  (pipe_q_s)
    );

    assign pipe_valid_s    = pipe_q_s[0];
    assign pipe_last_s     = pipe_q_s[1];

    assign addr_out        = addr_r;
    assign pixel_out       = pixel_in;
    assign pixel_valid_out = pipe_valid_s;
    assign pixel_last_out  = pipe_last_s;
    assign corner_width    = corner_width_r;
    assign corner_height   = corner_height_r;
    assign busy_out        = busy_r;
    assign done_out        = done_r;
    assign error_out       = error_r;

endmodule

// File: tb/tb_corner_scanner.sv
// Directed bench for corner_scanner with a 2-cycle BRAM model holding pixel[a] = a[15:0].
module tb_corner_scanner;

    logic        clk_in;
    logic        rst_in;
    logic        start_in;
    logic [7:0]  left_edge;
    logic [7:0]  right_edge;
    logic [8:0]  top_edge;
    logic [8:0]  bot_edge;
    logic [16:0] addr_out;
    logic [15:0] pixel_in;
    logic [15:0] pixel_out;
    logic        pixel_valid_out;
    logic        pixel_last_out;
    logic [7:0]  corner_width;
    logic [8:0]  corner_height;
    logic        busy_out;
    logic        done_out;
    logic        error_out;

    logic [16:0] rd_addr_r;

    int vectors;
    int miscompares;

    corner_scanner dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .start_in        (start_in),
        .left_edge       (left_edge),
        .right_edge      (right_edge),
        .top_edge        (top_edge),
        .bot_edge        (bot_edge),
        .addr_out        (addr_out),
        .pixel_in        (pixel_in),
        .pixel_out       (pixel_out),
        .pixel_valid_out (pixel_valid_out),
        .pixel_last_out  (pixel_last_out),
        .corner_width    (corner_width),
        .corner_height   (corner_height),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .error_out       (error_out)
    );

    // Clock generation.
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // BRAM model with two cycles of read latency.
    always @(posedge clk_in) begin
        rd_addr_r <= addr_out;
        pixel_in  <= rd_addr_r[15:0];
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic do_scan(input string nm,
                           input logic [7:0] l, input logic [7:0] r,
                           input logic [8:0] t, input logic [8:0] b,
                           input int exp_cw, input int exp_ch, input bit inject);
        int cyc, nvalid, first_v, last_idx, last_cyc, last_cnt, done_cyc, done_cnt, gaps, px, py;
        logic [31:0] ea;
        logic [31:0] first_addr;
        logic [31:0] last_addr;
        nvalid = 0; first_v = -1; last_idx = -1; last_cyc = -1; last_cnt = 0;
        done_cyc = -1; done_cnt = 0; gaps = 0; px = 0; py = 0; first_addr = 32'd0;
        last_addr = (int'(t) + exp_ch - 1) * 240 + int'(l) + exp_cw - 1;
        @(negedge clk_in);
        left_edge = l; right_edge = r; top_edge = t; bot_edge = b;
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        cyc = 1;
        chk({nm, " busy_in_setup"}, 32'(busy_out), 32'd1);
        while (cyc < exp_cw * exp_ch + 40 && done_cyc < 0) begin
            start_in = inject && (cyc == 20);
            if (inject && cyc == 20) begin
                left_edge = 8'd0; right_edge = 8'd7; top_edge = 9'd0; bot_edge = 9'd7;
            end
            if (cyc == 2) first_addr = 32'(addr_out);
            if (pixel_valid_out) begin
                if (first_v < 0) first_v = cyc;
                if (cyc != first_v + nvalid) gaps++;
                ea = (int'(t) + py) * 240 + int'(l) + px;
                chk({nm, " pixel"}, 32'(pixel_out), 32'(ea[15:0]));
                nvalid++;
                if (pixel_last_out) begin
                    last_idx = nvalid;
                    last_cyc = cyc;
                    last_cnt++;
                end
                px++;
                if (px == exp_cw) begin
                    px = 0;
                    py++;
                end
            end
            if (done_out) begin
                done_cyc = cyc;
                done_cnt++;
            end
            @(negedge clk_in);
            cyc++;
        end
        chk({nm, " corner_width"}, 32'(corner_width), 32'(exp_cw));
        chk({nm, " corner_height"}, 32'(corner_height), 32'(exp_ch));
        chk({nm, " first_addr"}, first_addr, 32'(int'(t) * 240 + int'(l)));
        chk({nm, " first_valid_cycle"}, 32'(first_v), 32'd4);
        chk({nm, " valid_count"}, 32'(nvalid), 32'(exp_cw * exp_ch));
        chk({nm, " last_index"}, 32'(last_idx), 32'(exp_cw * exp_ch));
        chk({nm, " last_count"}, 32'(last_cnt), 32'd1);
        chk({nm, " gaps"}, 32'(gaps), 32'd0);
        chk({nm, " done_cycle"}, 32'(done_cyc), 32'(last_cyc + 1));
        chk({nm, " done_count"}, 32'(done_cnt), 32'd1);
        chk({nm, " addr_hold"}, 32'(addr_out), last_addr);
        chk({nm, " busy_after"}, 32'(busy_out), 32'd0);
        chk({nm, " done_after"}, 32'(done_out), 32'd0);
    endtask

    task automatic do_reject(input string nm,
                             input logic [7:0] l, input logic [7:0] r,
                             input logic [8:0] t, input logic [8:0] b);
        logic [31:0] a0, cw0, ch0;
        int errs, busy_seen, addr_moves;
        errs = 0; busy_seen = 0; addr_moves = 0;
        a0 = 32'(addr_out); cw0 = 32'(corner_width); ch0 = 32'(corner_height);
        @(negedge clk_in);
        left_edge = l; right_edge = r; top_edge = t; bot_edge = b;
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (error_out) errs++;
            if (busy_out) busy_seen++;
            if (32'(addr_out) != a0) addr_moves++;
            @(negedge clk_in);
        end
        chk({nm, " error_pulses"}, 32'(errs), 32'd1);
        chk({nm, " busy_cycles"}, 32'(busy_seen), 32'd0);
        chk({nm, " addr_moves"}, 32'(addr_moves), 32'd0);
        chk({nm, " corner_width_kept"}, 32'(corner_width), cw0);
        chk({nm, " corner_height_kept"}, 32'(corner_height), ch0);
    endtask

    initial begin
        int stray;
        vectors = 0;
        miscompares = 0;
        rst_in = 1'b1;
        start_in = 1'b0;
        left_edge = 8'd0; right_edge = 8'd0; top_edge = 9'd0; bot_edge = 9'd0;
        repeat (3) @(negedge clk_in);

        // Reset state.
        chk("rst addr", 32'(addr_out), 32'd0);
        chk("rst valid", 32'(pixel_valid_out), 32'd0);
        chk("rst last", 32'(pixel_last_out), 32'd0);
        chk("rst cw", 32'(corner_width), 32'd0);
        chk("rst ch", 32'(corner_height), 32'd0);
        chk("rst busy", 32'(busy_out), 32'd0);
        chk("rst done", 32'(done_out), 32'd0);
        chk("rst error", 32'(error_out), 32'd0);
        rst_in = 1'b0;
        @(negedge clk_in);

        // Nominal card: 192x260 -> corner 48x65.
        do_scan("nominal", 8'd20, 8'd211, 9'd30, 9'd289, 48, 65, 1'b0);

        // Rejected edge sets.
        do_reject("rej_order", 8'd100, 8'd50, 9'd30, 9'd289);
        do_reject("rej_right", 8'd20, 8'd240, 9'd30, 9'd289);
        do_reject("rej_narrow", 8'd20, 8'd26, 9'd30, 9'd289);
        do_reject("rej_bot", 8'd20, 8'd211, 9'd30, 9'd320);

        // Start while busy is ignored.
        do_scan("busy_start", 8'd20, 8'd211, 9'd30, 9'd289, 48, 65, 1'b1);

        // Reset 100 cycles into a scan.
        @(negedge clk_in);
        left_edge = 8'd20; right_edge = 8'd211; top_edge = 9'd30; bot_edge = 9'd289;
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        repeat (99) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("abort addr", 32'(addr_out), 32'd0);
        chk("abort valid", 32'(pixel_valid_out), 32'd0);
        chk("abort last", 32'(pixel_last_out), 32'd0);
        chk("abort done", 32'(done_out), 32'd0);
        chk("abort busy", 32'(busy_out), 32'd0);
        chk("abort cw", 32'(corner_width), 32'd0);
        chk("abort ch", 32'(corner_height), 32'd0);
        rst_in = 1'b0;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            if (pixel_valid_out || pixel_last_out || done_out) stray++;
            @(negedge clk_in);
        end
        chk("abort stray_outputs", 32'(stray), 32'd0);
        do_scan("after_reset", 8'd20, 8'd211, 9'd30, 9'd289, 48, 65, 1'b0);

        // Smallest legal card: 8x8 -> corner 2x2, addresses 0, 1, 240, 241.
        do_scan("minimum", 8'd0, 8'd7, 9'd0, 9'd7, 2, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
